// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// master = datapath side (drives stage info), slave = the hazard controller.
interface hazard_ctrl_if #(
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  parameter int PERF_WIDTH             = 16
);
  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i;
  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i;
  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i;
  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i;
  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i;
  logic [1:0]                        ResultSrcE_i;
  logic                              PCSrcE_i;
  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i;
  logic                              RegWriteM_i;
  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i;
  logic                              RegWriteW_i;
  logic                              MemReqM_i;
  logic                              MemHitM_i;

  logic                              EnF_o;
  logic                              EnD_o;
  logic                              EnE_o;
  logic                              EnM_o;
  logic                              EnW_o;
  logic                              ClrD_o;
  logic                              ClrE_o;
  logic                              ClrM_o;
  logic [1:0]                        ForwardAE_o;
  logic [1:0]                        ForwardBE_o;
  logic                              MemReadyM_o;
  logic                              MissBusy_o;
  logic [PERF_WIDTH-1:0]             StallCount_o;
  logic [1:0]                        FsmStateDbg_o;

  modport master (
    output Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, ResultSrcE_i, PCSrcE_i,
           RdM_i, RegWriteM_i, RdW_i, RegWriteW_i, MemReqM_i, MemHitM_i,
    input  EnF_o, EnD_o, EnE_o, EnM_o, EnW_o, ClrD_o, ClrE_o, ClrM_o,
           ForwardAE_o, ForwardBE_o, MemReadyM_o, MissBusy_o, StallCount_o,
           FsmStateDbg_o
  );

  modport slave (
    input  Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, ResultSrcE_i, PCSrcE_i,
           RdM_i, RegWriteM_i, RdW_i, RegWriteW_i, MemReqM_i, MemHitM_i,
    output EnF_o, EnD_o, EnE_o, EnM_o, EnW_o, ClrD_o, ClrE_o, ClrM_o,
           ForwardAE_o, ForwardBE_o, MemReadyM_o, MissBusy_o, StallCount_o,
           FsmStateDbg_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, EX forwarding,
// fixed-penalty data-miss freeze FSM and a saturating frozen-cycle counter.
module hazard_ctrl #(
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  parameter int MISS_PENALTY           = 4,
  parameter int CNT_WIDTH              = 3,
  parameter int PERF_WIDTH             = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MISS   = 2'd1,
    S_RESUME = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] MISS_LOAD = CNT_WIDTH'(MISS_PENALTY - 1);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [PERF_WIDTH-1:0]  stall_q, stall_d;

  logic                   lw_stall;
  logic                   frozen;
  logic                   en_fd;

  function automatic logic [1:0] fwd_sel(
    input logic [REGISTER_ADDRESS_WIDTH-1:0] rs,
    input logic [REGISTER_ADDRESS_WIDTH-1:0] rd_m,
    input logic                              we_m,
    input logic [REGISTER_ADDRESS_WIDTH-1:0] rd_w,
    input logic                              we_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (we_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    lw_stall = (hz.ResultSrcE_i == 2'b01) && (hz.RdE_i != '0) &&
               ((hz.RdE_i == hz.Rs1D_i) || (hz.RdE_i == hz.Rs2D_i));
    frozen   = (state_q == S_MISS);
    en_fd    = !rst_i && !frozen && !lw_stall;
  end

  // Next state, miss countdown and frozen-cycle counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    case (state_q)
      S_IDLE: begin
        if (hz.MemReqM_i && !hz.MemHitM_i) begin
          state_d = S_MISS;
          cnt_d   = MISS_LOAD;
        end
      end
      S_MISS: begin
        if (cnt_q == '0) begin
          state_d = S_RESUME;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESUME: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (!en_fd && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  // Reset overrides everything so pipeline registers clear on each clock
  always_comb begin
    hz.EnF_o       = 1'b0;
    hz.EnD_o       = 1'b0;
    hz.EnE_o       = 1'b0;
    hz.EnM_o       = 1'b0;
    hz.EnW_o       = 1'b0;
    hz.ClrD_o      = 1'b1;
    hz.ClrE_o      = 1'b1;
    hz.ClrM_o      = 1'b1;
    hz.ForwardAE_o = 2'b00;
    hz.ForwardBE_o = 2'b00;
    hz.MemReadyM_o = 1'b0;
    hz.MissBusy_o  = 1'b0;
    if (!rst_i) begin
      hz.EnF_o       = en_fd;
      hz.EnD_o       = en_fd;
      hz.EnE_o       = !frozen;
      hz.EnM_o       = !frozen;
      hz.EnW_o       = !frozen;
      hz.ClrD_o      = !frozen && hz.PCSrcE_i;
      hz.ClrE_o      = !frozen && (lw_stall || hz.PCSrcE_i);
      hz.ClrM_o      = 1'b0;
      hz.ForwardAE_o = fwd_sel(hz.Rs1E_i, hz.RdM_i, hz.RegWriteM_i,
                               hz.RdW_i, hz.RegWriteW_i);
      hz.ForwardBE_o = fwd_sel(hz.Rs2E_i, hz.RdM_i, hz.RegWriteM_i,
                               hz.RdW_i, hz.RegWriteW_i);
      hz.MissBusy_o  = frozen;
      case (state_q)
        S_IDLE:   hz.MemReadyM_o = hz.MemReqM_i && hz.MemHitM_i;
        S_RESUME: hz.MemReadyM_o = 1'b1;
        default:  hz.MemReadyM_o = 1'b0;
      endcase
    end
  end

  assign hz.StallCount_o  = stall_q;
  assign hz.FsmStateDbg_o = state_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline hazard controller for the 5-stage RV32 core.
- Drives the enable and clear inputs of every pipeline register (F, D, E, M, W) and the execute-stage forwarding selects.
- Sequences data-memory miss stalls with a fixed-penalty FSM.
- Counts frozen cycles in a saturating performance counter.

Parameters:
- REGISTER_ADDRESS_WIDTH, 5, register index width.
- MISS_PENALTY, 4, frozen cycles per data-memory miss. Legal range 1..2**CNT_WIDTH.
- CNT_WIDTH, 3, miss counter width.
- PERF_WIDTH, 16, frozen-cycle counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- Rs1D_i  in  REGISTER_ADDRESS_WIDTH  decode source register 1.
- Rs2D_i  in  REGISTER_ADDRESS_WIDTH  decode source register 2.
- Rs1E_i  in  REGISTER_ADDRESS_WIDTH  execute source register 1.
- Rs2E_i  in  REGISTER_ADDRESS_WIDTH  execute source register 2.
- RdE_i  in  REGISTER_ADDRESS_WIDTH  execute destination register.
- ResultSrcE_i  in  2  execute result select; 2'b01 means load.
- PCSrcE_i  in  1  taken branch or jump resolved in execute.
- RdM_i  in  REGISTER_ADDRESS_WIDTH  memory-stage destination register.
- RegWriteM_i  in  1  memory-stage register write.
- RdW_i  in  REGISTER_ADDRESS_WIDTH  writeback destination register.
- RegWriteW_i  in  1  writeback register write.
- MemReqM_i  in  1  memory-stage load or store valid.
- MemHitM_i  in  1  data memory hit, qualified by MemReqM_i.
- EnF_o  out  1  PC register enable.
- EnD_o  out  1  F/D pipeline register enable.
- EnE_o  out  1  D/E pipeline register enable.
- EnM_o  out  1  E/M pipeline register enable.
- EnW_o  out  1  M/W pipeline register enable.
- ClrD_o  out  1  F/D synchronous clear.
- ClrE_o  out  1  D/E synchronous clear.
- ClrM_o  out  1  E/M synchronous clear.
- ForwardAE_o  out  2  ALU operand A select: 00 register file, 01 W, 10 M.
- ForwardBE_o  out  2  ALU operand B select, same encoding.
- MemReadyM_o  out  1  memory-stage access completes this cycle.
- MissBusy_o  out  1  miss FSM in MISS state.
- StallCount_o  out  PERF_WIDTH  saturating count of frozen cycles.

Behaviour:
- Pipeline registers give clear priority over enable. Therefore any Clr*_o asserted must coincide with the pipeline advancing.
- Reset, while rst_i is high:
  - FSM = IDLE, miss counter = 0, StallCount_o = 0.
  - All En*_o = 0, all Clr*_o = 1, so pipeline registers clear on each clock.
  - Forward*_o = 00, MemReadyM_o = 0, MissBusy_o = 0.
- FSM states: IDLE, MISS, RESUME.
  - IDLE: if MemReqM_i & !MemHitM_i, go to MISS and load counter with MISS_PENALTY-1. Otherwise stay. MemReadyM_o = MemReqM_i & MemHitM_i.
  - MISS: counter decrements each cycle; at 0 go to RESUME. MissBusy_o = 1. All En*_o = 0, all Clr*_o = 0, MemReadyM_o = 0.
  - RESUME: lasts exactly 1 cycle, then IDLE. MemReadyM_o = 1. Hit/miss is ignored (line just refilled); no re-entry to MISS.
- Freeze length: a miss freezes the pipeline for exactly MISS_PENALTY cycles. The instruction completes on the RESUME cycle.
- IDLE and RESUME: pipeline control is combinational.
  - lwStall = (ResultSrcE_i == 2'b01) & (RdE_i != 0) & ((RdE_i == Rs1D_i) | (RdE_i == Rs2D_i)).
  - EnF_o = EnD_o = !lwStall. EnE_o = EnM_o = EnW_o = 1.
  - ClrD_o = PCSrcE_i.
  - ClrE_o = lwStall | PCSrcE_i.
  - ClrM_o = 0.
- PCSrcE_i held during MISS: the flush is applied on the RESUME cycle. No flush pending register is needed, because the E stage is frozen.
- Forwarding is active in all states. For operand A:
  - 10 if RegWriteM_i & RdM_i != 0 & RdM_i == Rs1E_i;
  - else 01 if RegWriteW_i & RdW_i != 0 & RdW_i == Rs1E_i;
  - else 00.
  - M has priority over W. Operand B is identical using Rs2E_i.
- StallCount_o increments by 1 on every clock where EnF_o == 0, covering both load-use and MISS cycles. It saturates at all-ones.
- Reset mid-MISS: FSM returns to IDLE immediately (asynchronous); no MemReadyM_o pulse is produced.

Test Plan:
- Load-use: ResultSrcE_i=01, RdE_i=5, Rs1D_i=5 → EnF_o=EnD_o=0, ClrE_o=1, StallCount_o +1. Same stimulus with RdE_i=0 → no stall.
- Forwarding: RegWriteM_i=1, RdM_i=3, RegWriteW_i=1, RdW_i=3, Rs1E_i=3 → ForwardAE_o=10. Drop RegWriteM_i → 01. Rs2E_i=0 with RdW_i=0 → ForwardBE_o=00.
- Branch flush: PCSrcE_i=1 in IDLE → ClrD_o=ClrE_o=1, all En*_o=1. With lwStall also true → ClrE_o=1 and EnD_o=0.
- Miss, MISS_PENALTY=4: MemReqM_i=1, MemHitM_i=0 at cycle 0 → MissBusy_o=1 and all En*_o=0 for cycles 1–4; cycle 5 RESUME with MemReadyM_o=1 and En*_o=1; cycle 6 IDLE; StallCount_o=4.
- Flush during miss: PCSrcE_i=1 throughout a miss → Clr*_o=0 in MISS, ClrD_o=ClrE_o=1 only on the RESUME cycle.
- Async reset in the 2nd MISS cycle → outputs take reset values immediately, before the next edge; StallCount_o=0; after release the FSM is in IDLE.
